rr_arb_2x1: RTL and testbench

Two-input round-robin stream arbiter with packet lock. It sits directly upstream of the 2:1 select stage and produces the `sel` that steers it. It merges two valid/ready streams onto one registered output stream. Once a multi-beat packet has started, the grant stays on that input until its last beat is accepted.

---
 rtl/rr_arb_2x1_if.sv | 37 +++
 rtl/rr_arb_2x1.sv | 88 ++++++++
 tb/tb_rr_arb_2x1.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_arb_2x1_if.sv
// Signal bundle for the 2:1 round-robin stream arbiter: two input streams, one
// output stream, plus the steering select and lock status.
interface rr_arb_2x1_if #(
    parameter int WIDTH = 8
);
    logic             i0_valid;
    logic             i0_ready;
    logic [WIDTH-1:0] i0_data;
    logic             i0_last;
    logic             i1_valid;
    logic             i1_ready;
    logic [WIDTH-1:0] i1_data;
    logic             i1_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             sel;
    logic             busy;

    // master: the arbiter itself; slave: the sources and sink around it
    modport master (
        input  i0_valid, i0_data, i0_last,
        input  i1_valid, i1_data, i1_last,
        input  out_ready,
        output i0_ready, i1_ready,
        output out_valid, out_data, out_last, sel, busy
    );

    modport slave (
        output i0_valid, i0_data, i0_last,
        output i1_valid, i1_data, i1_last,
        output out_ready,
        input  i0_ready, i1_ready,
        input  out_valid, out_data, out_last, sel, busy
    );
endinterface

// File: rtl/rr_arb_2x1.sv
// Two-input round-robin stream arbiter with packet lock; registered output
// stream plus the sel that steers the downstream 2:1 select stage.
module rr_arb_2x1 #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    rr_arb_2x1_if.master  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e           state_q;
    logic             prio_q;
    logic             owner_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic             sel_q;

    logic load_en;
    logic i0_ready;
    logic i1_ready;
    logic accept0;
    logic accept1;

    // Readys never look at their own port's valid, so no valid->ready loop exists.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        i0_ready = 1'b0;
        i1_ready = 1'b0;
        load_en  = !out_valid_q || bus.out_ready;
        if (load_en) begin
            if (state_q == LOCK) begin
                i0_ready = !owner_q;
                i1_ready = owner_q;
            end else begin
                i0_ready = !bus.i1_valid || !prio_q;
                i1_ready = !bus.i0_valid ||  prio_q;
            end
        end
    end

    assign accept0 = bus.i0_valid && i0_ready;
    assign accept1 = bus.i1_valid && i1_ready;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sel_q       <= 1'b0;
        end else if (load_en) begin
            if (accept0 || accept1) begin
                out_valid_q <= 1'b1;
                out_data_q  <= accept1 ? bus.i1_data : bus.i0_data;
                out_last_q  <= accept1 ? bus.i1_last : bus.i0_last;
                sel_q       <= accept1;
                if (accept1 ? bus.i1_last : bus.i0_last) begin
                    state_q <= IDLE;
                    prio_q  <= !accept1;
                end else begin
                    state_q <= LOCK;
                    owner_q <= accept1;
                end
            end else begin
                // Bubble: payload and sel hold, lock (if any) is kept.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.i0_ready  = i0_ready;
    assign bus.i1_ready  = i1_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == LOCK);

endmodule

// File: tb/tb_rr_arb_2x1.sv
// Directed bench for rr_arb_2x1: a packet-level reference model checked every
// cycle, plus hand-computed expectations along the directed scenarios.
module tb_rr_arb_2x1;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    rr_arb_2x1_if #(.WIDTH(W)) bus ();

    rr_arb_2x1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the packet lock (-1 = nobody), whose turn is
    // next on contention, and the beat currently presented downstream.
    bit         m_live  = 1'b0;
    bit         m_ov;
    logic [7:0] m_od;
    bit         m_ol;
    bit         m_sel;
    int         m_owner;
    int         m_pref;

    function automatic bit m_ready(input int x);
        bit other_valid;
        other_valid = (x == 0) ? bus.i1_valid : bus.i0_valid;
        if (m_ov && !bus.out_ready) return 1'b0;
        if (m_owner >= 0)           return (x == m_owner);
        return !other_valid || (m_pref == x);
    endfunction

    always @(posedge clk) begin
        int w;
        if (!rst_n) begin
            m_live  = 1'b1;
            m_ov    = 1'b0;
            m_od    = 8'h00;
            m_ol    = 1'b0;
            m_sel   = 1'b0;
            m_owner = -1;
            m_pref  = 0;
        end else if (m_live && (!m_ov || bus.out_ready)) begin
            w = -1;
            if (bus.i0_valid && m_ready(0))      w = 0;
            else if (bus.i1_valid && m_ready(1)) w = 1;
            if (w < 0) begin
                m_ov = 1'b0;
            end else begin
                m_ov  = 1'b1;
                m_sel = (w == 1);
                m_od  = (w == 1) ? bus.i1_data : bus.i0_data;
                m_ol  = (w == 1) ? bus.i1_last : bus.i0_last;
                if (m_ol) begin
                    m_owner = -1;
                    m_pref  = 1 - w;
                end else begin
                    m_owner = w;
                end
            end
        end
    end

    // Per-cycle compare, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("model out_valid", bus.out_valid, m_ov);
            check("model out_data",  bus.out_data,  m_od);
            check("model out_last",  bus.out_last,  m_ol);
            check("model sel",       bus.sel,       m_sel);
            check("model busy",      bus.busy,      (m_owner >= 0));
            if (bus.i0_valid) check("model i0_ready", bus.i0_ready, m_ready(0));
            if (bus.i1_valid) check("model i1_ready", bus.i1_ready, m_ready(1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v0, input logic [7:0] d0, input bit l0,
                         input bit v1, input logic [7:0] d1, input bit l1);
        bus.i0_valid = v0; bus.i0_data = d0; bus.i0_last = l0;
        bus.i1_valid = v1; bus.i1_data = d1; bus.i1_last = l1;
        #1;
    endtask

    task automatic chk_out(input string name, input logic [7:0] d, input bit s,
                           input bit l, input bit b);
        check({name, " out_valid"}, bus.out_valid, 1'b1);
        check({name, " out_data"},  bus.out_data,  d);
        check({name, " sel"},       bus.sel,       s);
        check({name, " out_last"},  bus.out_last,  l);
        check({name, " busy"},      bus.busy,      b);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        drive(0, 8'h00, 0, 0, 8'h00, 0);

        // Reset then idle
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle out_valid", bus.out_valid, 1'b0);
        check("idle sel",       bus.sel,       1'b0);
        check("idle busy",      bus.busy,      1'b0);
        check("idle out_data",  bus.out_data,  8'h00);

        // Single-beat contention alternates starting with i0
        drive(1, 8'hA0, 1, 1, 8'hB1, 1);
        tick(); chk_out("rr1", 8'hA0, 0, 1, 0);
        tick(); chk_out("rr2", 8'hB1, 1, 1, 0);
        tick(); chk_out("rr3", 8'hA0, 0, 1, 0);
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        tick(); check("rr drain out_valid", bus.out_valid, 1'b0);

        // Packet lock on i0 while i1 waits
        drive(1, 8'h11, 0, 0, 8'h00, 0);
        tick(); chk_out("lock1", 8'h11, 0, 0, 1);
        drive(1, 8'h12, 0, 1, 8'h55, 1);
        check("lock i1_ready a", bus.i1_ready, 1'b0);
        tick(); chk_out("lock2", 8'h12, 0, 0, 1);
        drive(1, 8'h13, 1, 1, 8'h55, 1);
        check("lock i1_ready b", bus.i1_ready, 1'b0);
        tick(); chk_out("lock3", 8'h13, 0, 1, 0);
        drive(0, 8'h00, 0, 1, 8'h55, 1);
        tick(); chk_out("lock i1", 8'h55, 1, 1, 0);
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        tick();

        // Backpressure holds the beat and blocks both inputs
        drive(1, 8'h22, 1, 0, 8'h00, 0);
        tick(); chk_out("bp load", 8'h22, 0, 1, 0);
        bus.out_ready = 1'b0;
        drive(1, 8'h23, 1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            check("bp i0_ready", bus.i0_ready, 1'b0);
            tick(); chk_out("bp hold", 8'h22, 0, 1, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp release i0_ready", bus.i0_ready, 1'b1);
        tick(); chk_out("bp next", 8'h23, 0, 1, 0);
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        tick(); check("bp drain out_valid", bus.out_valid, 1'b0);

        // Bubble inside an i1 packet; i0 must wait for the last beat
        drive(1, 8'h41, 1, 1, 8'h31, 0);
        tick(); chk_out("bub first", 8'h31, 1, 0, 1);
        drive(1, 8'h41, 1, 0, 8'h00, 0);
        for (int i = 0; i < 2; i++) begin
            check("bub i0_ready", bus.i0_ready, 1'b0);
            tick();
            check("bub out_valid", bus.out_valid, 1'b0);
            check("bub busy",      bus.busy,      1'b1);
        end
        drive(1, 8'h41, 1, 1, 8'h32, 1);
        check("bub i0_ready end", bus.i0_ready, 1'b0);
        tick(); chk_out("bub last", 8'h32, 1, 1, 0);
        drive(1, 8'h41, 1, 0, 8'h00, 0);
        tick(); chk_out("bub i0", 8'h41, 0, 1, 0);
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        tick();

        // Reset mid-packet drops the lock and the in-flight beat
        drive(1, 8'h61, 0, 0, 8'h00, 0);
        tick(); chk_out("mid b1", 8'h61, 0, 0, 1);
        drive(1, 8'h62, 0, 0, 8'h00, 0);
        tick(); chk_out("mid b2", 8'h62, 0, 0, 1);
        drive(1, 8'h63, 0, 1, 8'h77, 1);
        rst_n = 1'b0;
        tick();
        check("mid rst out_valid", bus.out_valid, 1'b0);
        check("mid rst busy",      bus.busy,      1'b0);
        check("mid rst out_data",  bus.out_data,  8'h00);
        rst_n = 1'b1;
        drive(0, 8'h00, 0, 1, 8'h77, 1);
        tick(); chk_out("post rst i1", 8'h77, 1, 1, 0);
        drive(1, 8'h81, 1, 1, 8'h82, 1);
        tick(); chk_out("post rst rr", 8'h81, 0, 1, 0);
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
